// File: rtl/expand_n_scale.sv
// expand_n_scale: widens Wn-bit signed samples to Win bits by a runtime
// left shift with saturation, in a 2-stage valid/ready pipeline.
// Ports: clk, reset (sync, active high); din/din_valid/din_ready/shift in;
// dout/dout_valid/dout_ready out; sat_flag/sat_count stats, stat_clear.
// Optional: `define EXPAND_N_SCALE_DITHER_EN fills vacated LSBs from an LFSR.
module expand_n_scale #(
  parameter  int Win    = 16,
  parameter  int Nsat   = 1,
  parameter  int Nround = 5,
  localparam int Wn     = Win - Nsat - Nround,
  localparam int Wsh    = $clog2(Win)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [Wn-1:0]  din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [Wsh-1:0]        shift,
  output logic signed [Win-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  sat_flag,
  output logic [15:0]           sat_count,
  input  logic                  stat_clear
);

  localparam int Wp = 2 * Win;

  logic          s1_valid;
  logic [Wp-1:0] s1_prod;
  logic          s2_sat;
  logic          s1_adv;
  logic          in_xfer;
  logic          out_xfer;
  logic [Wp-1:0] prod_c;
  logic [Win-1:0] sat_val;
  logic          sat_c;
  logic [Win:0]  top_bits;

  assign s1_adv    = s1_valid & (~dout_valid | dout_ready);
  assign din_ready = ~s1_valid | s1_adv;
  assign in_xfer   = din_valid & din_ready;
  assign out_xfer  = dout_valid & dout_ready;

`ifdef EXPAND_N_SCALE_DITHER_EN
  logic [15:0] lfsr;
  logic [15:0] dmask;
  logic        lfsr_fb;

  // Right-shifting form of x^16+x^14+x^13+x^11+1.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign dmask   = (16'd1 << shift) - 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (in_xfer) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  // Vacated LSBs are zero, so OR-ing the dither in is exact.
  always_comb begin
    prod_c = {{(Wp-Wn){din[Wn-1]}}, din} << shift;
    prod_c = prod_c | Wp'(lfsr & dmask);
  end
`else
  always_comb begin
    prod_c = {{(Wp-Wn){din[Wn-1]}}, din} << shift;
  end
`endif

  // In range iff every bit from Win-1 upward equals the sign bit.
  always_comb begin
    top_bits = s1_prod[Wp-1:Win-1];
    sat_c    = ~(&top_bits | ~|top_bits);
    if (s1_prod[Wp-1]) begin
      sat_val = {1'b1, {(Win-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(Win-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
    end else if (din_ready) begin
      s1_valid <= din_valid;
      if (din_valid) begin
        s1_prod <= prod_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      s2_sat     <= 1'b0;
    end else if (~dout_valid | dout_ready) begin
      dout_valid <= s1_valid;
      if (s1_valid) begin
        dout   <= sat_c ? sat_val : s1_prod[Win-1:0];
        s2_sat <= sat_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (out_xfer && s2_sat) begin
      sat_flag <= 1'b1;
      if (sat_count != 16'hFFFF) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_expand_n_scale.sv
// Bench for expand_n_scale: directed table, stall/reset/clear sequences
// and random traffic against an arithmetic scoreboard model.
module tb_expand_n_scale;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [3:0]  shift;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        sat_flag;
  logic [15:0] sat_count;
  logic        stat_clear;

  expand_n_scale dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .shift      (shift),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sat_flag   (sat_flag),
    .sat_count  (sat_count),
    .stat_clear (stat_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    bit          sat;
  } exp_t;

  typedef struct {
    logic [9:0]  din;
    logic [3:0]  sh;
    logic [15:0] exp;
    bit          sat;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  exp_t        q[$];
  int          mcount = 0;
  bit          mflag = 0;
  logic [15:0] mlfsr = 16'hACE1;
  bit          acc, outv, held;
  logic [15:0] hold_dout;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t ref_out(logic [9:0] d, logic [3:0] s,
                                   logic [15:0] l);
    exp_t e;
    int v;
    v = $signed(d) * (1 << s);
    if (v > 32767) begin
      e.val = 16'h7FFF; e.sat = 1;
    end else if (v < -32768) begin
      e.val = 16'h8000; e.sat = 1;
    end else begin
      e.val = v[15:0]; e.sat = 0;
    end
`ifdef EXPAND_N_SCALE_DITHER_EN
    if (!e.sat) e.val = e.val | (l & ((16'd1 << s) - 16'd1));
`else
    l = 16'h0;
    e.val = e.val | l;
`endif
    return e;
  endfunction

  // One clock: sample at negedge+1, update model, step to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    check("sat_count", sat_count, mcount);
    check("sat_flag", sat_flag, mflag);
    if (held && !reset) begin
      check("hold_valid", dout_valid, 1);
      check("hold_dout", dout, hold_dout);
    end
    acc = 0; outv = 0;
    if (reset) begin
      q.delete();
      mcount = 0; mflag = 0; mlfsr = 16'hACE1;
    end else begin
      outv = dout_valid && dout_ready;
      if (outv) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("dout", dout, e.val);
          if (e.sat) begin
            mflag = 1;
            if (mcount != 16'hFFFF) mcount++;
          end
        end
      end
      if (stat_clear) begin
        mcount = 0; mflag = 0;
      end
      acc = din_valid && din_ready;
      if (acc) begin
        q.push_back(ref_out(din, shift, mlfsr));
        mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
      end
    end
    held = dout_valid && !dout_ready && !reset;
    hold_dout = dout;
    @(negedge clk);
  endtask

  vec_t        vt[11];
  logic [9:0]  sd[5];
  logic [15:0] lf, ex;
  int          k, outs;

  initial begin
    vt[0]  = '{10'h1FF, 4'd5,  16'h3FE0, 0};
    vt[1]  = '{10'h200, 4'd5,  16'hC000, 0};
    vt[2]  = '{10'h200, 4'd6,  16'h8000, 0};
    vt[3]  = '{10'h1FF, 4'd7,  16'h7FFF, 1};
    vt[4]  = '{10'h200, 4'd7,  16'h8000, 1};
    vt[5]  = '{10'h3FF, 4'd15, 16'h8000, 0};
    vt[6]  = '{10'h001, 4'd15, 16'h7FFF, 1};
    vt[7]  = '{10'h1FF, 4'd6,  16'h7FC0, 0};
    vt[8]  = '{10'h155, 4'd3,  16'h0AA8, 0};
    vt[9]  = '{10'h2AB, 4'd3,  16'hF558, 0};
    vt[10] = '{10'h3FF, 4'd0,  16'hFFFF, 0};

    reset = 1; din = 0; din_valid = 0; shift = 4'd5;
    dout_ready = 1; stat_clear = 0; held = 0;
    @(negedge clk);
    tick(); tick();
    reset = 0;
    #1;
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_din_ready", din_ready, 1);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_count", sat_count, 0);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      din = vt[i].din; shift = vt[i].sh;
      din_valid = 1; dout_ready = 1;
      lf = mlfsr;
      tick();
      check("tbl_accept", acc, 1);
      din_valid = 0;
      check("tbl_lat1", dout_valid, 0);
      tick();
      ex = vt[i].exp;
`ifdef EXPAND_N_SCALE_DITHER_EN
      if (!vt[i].sat) ex = ex | (lf & ((16'd1 << vt[i].sh) - 16'd1));
`endif
      check("tbl_lat2", dout_valid, 1);
      check("tbl_dout", dout, ex);
      tick();
      if (i == 4) begin
        check("tbl_cnt2", sat_count, 2);
        check("tbl_flag1", sat_flag, 1);
      end
    end

    for (int i = 0; i < 5; i++) sd[i] = 10'($urandom);
    dout_ready = 0; din_valid = 1; k = 0;
    for (int c = 0; c < 4; c++) begin
      din = sd[k]; shift = 4'($urandom_range(0, 6));
      tick();
      if (acc) k++;
    end
    check("stall_accepts", k, 2);
    check("stall_ready", din_ready, 0);
    dout_ready = 1; outs = 0;
    for (int c = 0; c < 5; c++) begin
      din_valid = (k < 5);
      din = sd[k % 5]; shift = 4'($urandom_range(0, 6));
      tick();
      if (outv) outs++;
      if (acc) k++;
    end
    check("stall_outs", outs, 5);
    check("stall_total", k, 5);
    din_valid = 0;
    tick(); tick();
    check("stall_drain", q.size(), 0);

    dout_ready = 0; din_valid = 1;
    din = 10'h1FF; shift = 4'd7;
    tick(); tick(); tick();
    check("full_ready", din_ready, 0);
    reset = 1; din_valid = 0;
    tick();
    reset = 0;
    #1;
    check("rst2_valid", dout_valid, 0);
    check("rst2_ready", din_ready, 1);
    check("rst2_count", sat_count, 0);
    @(negedge clk);

    dout_ready = 0; din_valid = 1;
    din = 10'h200; shift = 4'd9;
    tick();
    din_valid = 0;
    tick(); tick();
    check("clr_pending", dout_valid, 1);
    stat_clear = 1; dout_ready = 1;
    tick();
    stat_clear = 0;
    check("clr_count", sat_count, 0);
    check("clr_flag", sat_flag, 0);

    for (int c = 0; c < 400; c++) begin
      din = 10'($urandom);
      shift = 4'($urandom_range(0, 15));
      din_valid = ($urandom_range(0, 3) != 0);
      dout_ready = ($urandom_range(0, 3) != 0);
      stat_clear = ($urandom_range(0, 31) == 0);
      tick();
    end
    din_valid = 0; dout_ready = 1; stat_clear = 0;
    for (int c = 0; c < 10; c++) tick();
    check("rand_drain", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/expand_n_scale.md
Name: expand_n_scale

Overview:
- Streaming widener for the filter data path; the inverse direction of the round-and-saturate narrowing stage.
- Takes narrow signed samples of width Wn = Win-Nsat-Nround and rescales them to Win bits by a runtime left shift.
- Saturates on overflow. Uses a 2-stage valid/ready pipeline with full backpressure.
- Sits between narrowed coefficient/state storage and the wide filter arithmetic, or in front of a DAC interface.

Parameters:
- Win, 16, output sample width (signed two's complement).
- Nsat, 1, headroom bits removed by the narrowing stage; used only to derive Wn.
- Nround, 5, LSBs removed by the narrowing stage; used to derive Wn and as the shift reset value.
- Wn, Win-Nsat-Nround (10), input sample width (derived localparam, not overridable).
- Wsh, $clog2(Win) (4), width of the shift control.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- din  in  Wn  signed input sample.
- din_valid  in  1  input sample valid.
- din_ready  out  1  block can accept an input this cycle.
- shift  in  Wsh  left-shift amount, 0..Win-1; sampled together with din on acceptance.
- dout  out  Win  signed scaled output sample.
- dout_valid  out  1  output sample valid.
- dout_ready  in  1  downstream accepts dout this cycle.
- sat_flag  out  1  sticky: at least one output saturated since reset/clear.
- sat_count  out  16  number of saturated outputs; holds at 16'hFFFF.
- stat_clear  in  1  synchronous clear of sat_flag and sat_count.

Behaviour:
- Reset values:
  - dout = 0, dout_valid = 0, sat_flag = 0, sat_count = 0.
  - Both pipeline stages empty; din_ready = 1 in the first cycle after reset.
- Handshakes:
  - Input transfer when din_valid & din_ready.
  - Output transfer when dout_valid & dout_ready.
  - dout and dout_valid must stay stable while dout_valid & !dout_ready.
- Stage 1 (S1):
  - On input transfer, register din sign-extended to 2*Win bits and shifted left by shift.
  - Also register the shift value.
- Stage 2 (S2):
  - Saturate the S1 product to Win bits: >  2^(Win-1)-1 gives 2^(Win-1)-1 (16'h7FFF); < -2^(Win-1) gives -2^(Win-1) (16'h8000); otherwise pass low Win bits.
  - Register the result as dout.
  - Register a per-sample sat bit alongside dout.
- Pipeline advance:
  - S2 loads from S1 when S2 is empty or its output transfers this cycle.
  - S1 loads when S1 is empty or S1 moves to S2 this cycle.
  - din_ready = !S1_valid | s1_advance (combinational from dout_ready; no bubble).
- Latency and throughput:
  - Accepted sample appears on dout exactly 2 cycles later when dout_ready is held high.
  - Throughput is 1 sample/cycle.
- Stall: with dout_ready low, the block holds at most 2 samples; din_ready drops once both stages are full. No sample is lost or duplicated.
- Statistics:
  - sat_count increments by 1 and sat_flag sets on each output transfer whose sat bit is 1.
  - stat_clear has priority over a same-cycle increment: the result is 0 and sat_flag is 0.
- Shift semantics:
  - shift = Nround exactly undoes the narrowing scale; no saturation is possible for shift ≤ Nsat+Nround.
  - shift > Nsat+Nround may saturate.
  - Changing shift mid-stream affects only samples accepted afterwards.
- Reset mid-operation: in-flight samples are discarded and the statistics are cleared.

Optional Feature:
- Macro: EXPAND_N_SCALE_DITHER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seeded 16'hACE1 on reset) advances once per input transfer.
  - Its low `shift` bits are OR-ed into the zero LSBs vacated by the shift in S1.
  - Dither is never applied to a saturated result.
  - shift = 0 adds no dither.
- When undefined:
  - Vacated LSBs are 0 and no LFSR exists.
  - The output is a pure deterministic shift-and-saturate.

Test Plan:
- Reset release, then din = 10'h1FF, shift = 5, dout_ready = 1 → dout = 16'h3FE0 two cycles after acceptance; sat_flag = 0.
- din = 10'h200 (-512), shift = 5 → dout = 16'hC000; then shift = 6 → dout = 16'h8000, no saturation (exact), sat_count = 0.
- din = 10'h1FF, shift = 7 → dout = 16'h7FFF. din = 10'h200, shift = 7 → dout = 16'h8000. Expected sat_count = 2, sat_flag = 1.
- Stall: stream 5 samples with dout_ready = 0 for 4 cycles → din_ready falls after 2 accepts; after release all 5 emerge in order, unchanged, 1/cycle.
- stat_clear asserted in the same cycle as a saturating output transfer → sat_count = 0 and sat_flag = 0 next cycle.
- Reset asserted with both stages full → next cycle dout_valid = 0, din_ready = 1, sat_count = 0. With EXPAND_N_SCALE_DITHER_EN: din = 0, shift = 4 → dout[15:4] = 0 and dout[3:0] = LFSR[3:0], matching the model sequence from seed 16'hACE1.
